// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: slot order (c0 rd, c0 wr, c1 rd, c1 wr) and FSM state encodings for sram_port_arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {SLOT_C0_RD, SLOT_C0_WR, SLOT_C1_RD, SLOT_C1_WR} slot_t;
  typedef enum logic [1:0] {IDLE, WAIT, REJECT, DONE} state_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: two-client level request/pulse response bus plus SRAM controller side; slave = arbiter view, master = environment view
interface sram_port_arbiter_if #(
  parameter int data_width = 16,
  parameter int sram_addr_width = 12
);
  logic c0_req_sram_read, c0_req_sram_write, c1_req_sram_read, c1_req_sram_write;
  logic [sram_addr_width-1:0] c0_req_sram_read_addr, c0_req_sram_write_addr;
  logic [sram_addr_width-1:0] c1_req_sram_read_addr, c1_req_sram_write_addr;
  logic [data_width-1:0] c0_data_to_sram, c1_data_to_sram;
  logic c0_sram_read_ready, c0_sram_write_ready, c0_sram_read_invalid, c0_sram_write_invalid;
  logic c1_sram_read_ready, c1_sram_write_ready, c1_sram_read_invalid, c1_sram_write_invalid;
  logic [data_width-1:0] c0_data_from_sram, c1_data_from_sram;
  logic mem_req, mem_write, mem_ack, mem_err, busy;
  logic [sram_addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata, mem_rdata;
  modport slave (
    input c0_req_sram_read, c0_req_sram_write, c1_req_sram_read, c1_req_sram_write,
    input c0_req_sram_read_addr, c0_req_sram_write_addr, c1_req_sram_read_addr, c1_req_sram_write_addr,
    input c0_data_to_sram, c1_data_to_sram, mem_ack, mem_err, mem_rdata,
    output c0_sram_read_ready, c0_sram_write_ready, c0_sram_read_invalid, c0_sram_write_invalid,
    output c1_sram_read_ready, c1_sram_write_ready, c1_sram_read_invalid, c1_sram_write_invalid,
    output c0_data_from_sram, c1_data_from_sram, mem_req, mem_write, mem_addr, mem_wdata, busy
  );
  modport master (
    output c0_req_sram_read, c0_req_sram_write, c1_req_sram_read, c1_req_sram_write,
    output c0_req_sram_read_addr, c0_req_sram_write_addr, c1_req_sram_read_addr, c1_req_sram_write_addr,
    output c0_data_to_sram, c1_data_to_sram, mem_ack, mem_err, mem_rdata,
    input c0_sram_read_ready, c0_sram_write_ready, c0_sram_read_invalid, c0_sram_write_invalid,
    input c1_sram_read_ready, c1_sram_write_ready, c1_sram_read_invalid, c1_sram_write_invalid,
    input c0_data_from_sram, c1_data_from_sram, mem_req, mem_write, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sram_port_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker; req[3:0], ptr[1:0] in; valid, grant[1:0] = first active slot from ptr upward mod 4
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] grant
);
  always_comb begin
    valid = |req;
    grant = ptr;
    for (int i = 3; i >= 0; i--) if (req[ptr + 2'(i)]) grant = ptr + 2'(i);
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin share of one SRAM controller between two clients; ports clk, reset_n (sync active-low), bus (slave modport: client requests/pulses, mem_* side, busy)
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int data_width = 16,
  parameter int sram_addr_width = 12,
  parameter int sram_capacity = 8096,
  parameter int timeout_cycles = 255
) (
  input logic clk,
  input logic reset_n,
  sram_port_arbiter_if.slave bus
);
  localparam int AW = sram_addr_width;
  localparam int DW = data_width;
  localparam int XW = AW > $clog2(sram_capacity) + 1 ? AW : $clog2(sram_capacity) + 1;
  localparam int CW = timeout_cycles > 0 ? $clog2(timeout_cycles + 1) : 1;
  state_t state, state_nx;
  slot_t slot_q;
  logic [1:0] rr_ptr, grant;
  logic valid, in_range, tmo, fail, ok_q, bad_q, rdy, inv;
  logic [AW-1:0] addr_q, pick_addr;
  logic [DW-1:0] wdata_q, d0, d1;
  logic [CW-1:0] cnt;
  rr_pick4 u_pick (
    .req({bus.c1_req_sram_write, bus.c1_req_sram_read, bus.c0_req_sram_write, bus.c0_req_sram_read}),
    .ptr(rr_ptr),
    .valid(valid),
    .grant(grant)
  );
  assign pick_addr = grant[1] ? (grant[0] ? bus.c1_req_sram_write_addr : bus.c1_req_sram_read_addr)
                              : (grant[0] ? bus.c0_req_sram_write_addr : bus.c0_req_sram_read_addr);
  assign in_range = XW'(pick_addr) < XW'(sram_capacity);
  // cnt counts completed WAIT cycles, so mem_req stays up for exactly timeout_cycles cycles
  assign tmo = timeout_cycles != 0 && cnt == CW'(timeout_cycles - 1);
  assign fail = bus.mem_err || tmo;
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE   ? (valid ? (in_range ? WAIT : REJECT) : IDLE)
             : state == WAIT   ? ((fail || bus.mem_ack) ? DONE : WAIT)
             : state == REJECT ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_q <= SLOT_C0_RD;
      addr_q <= '0;
      wdata_q <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      ok_q <= 1'b0;
      bad_q <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      if (state == IDLE && valid) begin
        slot_q <= slot_t'(grant);
        addr_q <= pick_addr;
        wdata_q <= grant[1] ? bus.c1_data_to_sram : bus.c0_data_to_sram;
        rr_ptr <= grant + 2'd1;
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      bad_q <= state == WAIT && fail;
      ok_q <= state == WAIT && bus.mem_ack && !fail;
      if (state == WAIT && bus.mem_ack && !fail && slot_q == SLOT_C0_RD) d0 <= bus.mem_rdata;
      if (state == WAIT && bus.mem_ack && !fail && slot_q == SLOT_C1_RD) d1 <= bus.mem_rdata;
    end
  end
  always_comb begin
    rdy = state == DONE && ok_q;
    inv = state == REJECT || (state == DONE && bad_q);
    bus.mem_req = state == WAIT;
    bus.mem_write = state == WAIT && slot_q[0];
    bus.mem_addr = state == WAIT ? addr_q : '0;
    bus.mem_wdata = state == WAIT ? wdata_q : '0;
    bus.busy = state != IDLE;
    bus.c0_sram_read_ready = rdy && slot_q == SLOT_C0_RD;
    bus.c0_sram_write_ready = rdy && slot_q == SLOT_C0_WR;
    bus.c1_sram_read_ready = rdy && slot_q == SLOT_C1_RD;
    bus.c1_sram_write_ready = rdy && slot_q == SLOT_C1_WR;
    bus.c0_sram_read_invalid = inv && slot_q == SLOT_C0_RD;
    bus.c0_sram_write_invalid = inv && slot_q == SLOT_C0_WR;
    bus.c1_sram_read_invalid = inv && slot_q == SLOT_C1_RD;
    bus.c1_sram_write_invalid = inv && slot_q == SLOT_C1_WR;
    bus.c0_data_from_sram = d0;
    bus.c1_data_from_sram = d1;
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  sram_port_arbiter_if #(.data_width(16), .sram_addr_width(13)) bus ();
  sram_port_arbiter #(
    .data_width(16),
    .sram_addr_width(13),
    .sram_capacity(8096),
    .timeout_cycles(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  int pc[8] = '{default: 0};
  int snap[8] = '{default: 0};
  int mreq_cyc = 0;
  int multi = 0;
  logic [7:0] p;
  assign p = {bus.c1_sram_write_invalid, bus.c1_sram_read_invalid, bus.c0_sram_write_invalid,
              bus.c0_sram_read_invalid, bus.c1_sram_write_ready, bus.c1_sram_read_ready,
              bus.c0_sram_write_ready, bus.c0_sram_read_ready};
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) if (p[i]) pc[i]++;
    if ($countones(p) > 1) multi++;
    if (bus.mem_req) mreq_cyc++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_req;
    for (int i = 0; i < 20 && !bus.mem_req; i++) tick();
    check("req_wait", 32'(bus.mem_req), 1);
  endtask
  task automatic ack(input logic err, input logic [15:0] rd);
    bus.mem_ack = 1'b1;
    bus.mem_err = err;
    bus.mem_rdata = rd;
    tick();
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
  endtask
  task automatic drop;
    bus.c0_req_sram_read = 1'b0;
    bus.c0_req_sram_write = 1'b0;
    bus.c1_req_sram_read = 1'b0;
    bus.c1_req_sram_write = 1'b0;
  endtask
  int exp_addr[5] = '{1, 2, 3, 4, 1};
  int exp_wr[5] = '{0, 1, 0, 1, 0};
  int m0;
  initial begin
    drop();
    bus.c0_req_sram_read_addr = '0;
    bus.c0_req_sram_write_addr = '0;
    bus.c1_req_sram_read_addr = '0;
    bus.c1_req_sram_write_addr = '0;
    bus.c0_data_to_sram = '0;
    bus.c1_data_to_sram = '0;
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) tick();
    check("rst_pulses", 32'(p), 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_d0", 32'(bus.c0_data_from_sram), 0);
    check("rst_d1", 32'(bus.c1_data_from_sram), 0);
    reset_n = 1'b1;
    tick();
    bus.c0_req_sram_read_addr = 13'h010;
    bus.c0_req_sram_read = 1'b1;
    wait_req();
    check("t1_addr", 32'(bus.mem_addr), 32'h010);
    check("t1_write", 32'(bus.mem_write), 0);
    tick();
    ack(1'b0, 16'hBEEF);
    check("t1_pulse", 32'(p), 32'h01);
    check("t1_data", 32'(bus.c0_data_from_sram), 32'hBEEF);
    check("t1_req_drop", 32'(bus.mem_req), 0);
    drop();
    tick();
    check("t1_pulse_end", 32'(p), 0);
    reset_n = 1'b0;
    bus.c0_req_sram_read_addr = 13'd1;
    bus.c0_req_sram_write_addr = 13'd2;
    bus.c1_req_sram_read_addr = 13'd3;
    bus.c1_req_sram_write_addr = 13'd4;
    bus.c0_req_sram_read = 1'b1;
    bus.c0_req_sram_write = 1'b1;
    bus.c1_req_sram_read = 1'b1;
    bus.c1_req_sram_write = 1'b1;
    tick();
    tick();
    snap = pc;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_req();
      check($sformatf("t2_addr%0d", k), 32'(bus.mem_addr), 32'(exp_addr[k]));
      check($sformatf("t2_wr%0d", k), 32'(bus.mem_write), 32'(exp_wr[k]));
      ack(1'b0, 16'h1000 + 16'(k));
    end
    drop();
    tick();
    tick();
    check("t2_c0_rd_cnt", 32'(pc[0] - snap[0]), 2);
    check("t2_c0_wr_cnt", 32'(pc[1] - snap[1]), 1);
    check("t2_c1_rd_cnt", 32'(pc[2] - snap[2]), 1);
    check("t2_c1_wr_cnt", 32'(pc[3] - snap[3]), 1);
    check("t2_d1", 32'(bus.c1_data_from_sram), 32'h1002);
    m0 = mreq_cyc;
    bus.c1_req_sram_write_addr = 13'd8096;
    bus.c1_data_to_sram = 16'hAAAA;
    bus.c1_req_sram_write = 1'b1;
    tick();
    check("t3_inv", 32'(p), 32'h80);
    check("t3_busy", 32'(bus.busy), 1);
    tick();
    check("t3_inv_end", 32'(p), 0);
    drop();
    tick();
    check("t3_no_mem_req", 32'(mreq_cyc - m0), 0);
    bus.c1_req_sram_write_addr = 13'd8095;
    bus.c1_req_sram_write = 1'b1;
    wait_req();
    check("t3_edge_addr", 32'(bus.mem_addr), 32'd8095);
    check("t3_edge_wdata", 32'(bus.mem_wdata), 32'hAAAA);
    ack(1'b0, 16'h0);
    check("t3_edge_rdy", 32'(p), 32'h08);
    drop();
    tick();
    bus.c0_req_sram_write_addr = 13'h020;
    bus.c0_data_to_sram = 16'h1234;
    bus.c0_req_sram_write = 1'b1;
    tick();
    check("t4_req", 32'(bus.mem_req), 1);
    check("t4_write", 32'(bus.mem_write), 1);
    check("t4_wdata", 32'(bus.mem_wdata), 32'h1234);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("t4_hold%0d", k), 32'(bus.mem_req), 1);
    end
    tick();
    check("t4_tmo_inv", 32'(p), 32'h20);
    check("t4_req_drop", 32'(bus.mem_req), 0);
    drop();
    tick();
    bus.c0_req_sram_read_addr = 13'h030;
    bus.c0_req_sram_read = 1'b1;
    wait_req();
    check("t4_next_addr", 32'(bus.mem_addr), 32'h030);
    ack(1'b0, 16'h5A5A);
    check("t4_next_rdy", 32'(p), 32'h01);
    check("t4_next_data", 32'(bus.c0_data_from_sram), 32'h5A5A);
    drop();
    tick();
    ack(1'b0, 16'hFFFF);
    check("idle_ack_pulse", 32'(p), 0);
    check("idle_ack_data", 32'(bus.c0_data_from_sram), 32'h5A5A);
    check("idle_ack_busy", 32'(bus.busy), 0);
    bus.c0_req_sram_read_addr = 13'h040;
    bus.c0_req_sram_read = 1'b1;
    wait_req();
    ack(1'b1, 16'hDEAD);
    check("t5_inv", 32'(p), 32'h10);
    check("t5_data", 32'(bus.c0_data_from_sram), 32'h5A5A);
    drop();
    tick();
    bus.c0_req_sram_read_addr = 13'h050;
    bus.c1_req_sram_read_addr = 13'h060;
    bus.c0_req_sram_read = 1'b1;
    wait_req();
    check("t6_addr", 32'(bus.mem_addr), 32'h050);
    snap = pc;
    reset_n = 1'b0;
    bus.c1_req_sram_read = 1'b1;
    ack(1'b0, 16'h7777);
    check("t6_rst_req", 32'(bus.mem_req), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_pulses", 32'(p), 0);
    check("t6_rst_d0", 32'(bus.c0_data_from_sram), 0);
    tick();
    reset_n = 1'b1;
    wait_req();
    check("t6_first_slot", 32'(bus.mem_addr), 32'h050);
    check("t6_no_pulse", 32'((pc[0] - snap[0]) + (pc[4] - snap[4]) + (pc[2] - snap[2]) + (pc[6] - snap[6])), 0);
    ack(1'b0, 16'h1357);
    check("t6_rdy", 32'(p), 32'h01);
    drop();
    tick();
    tick();
    check("one_pulse_per_cycle", 32'(multi), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
